// File: rtl/sprite_sequencer_if.sv
// Bundle of display-timing inputs, user controls and sprite-engine outputs
// for one sprite sequencer. The display side is the master; the sequencer
// itself connects through the slave modport.
interface sprite_sequencer_if #(
  parameter int CORDW = 16,
  parameter int ADDRW = 11
);
  logic                    i_frame;
  logic                    i_line;
  logic signed [CORDW-1:0] i_sy;
  logic                    i_run;
  logic                    i_key_n;
  logic                    i_dir;
  logic signed [CORDW-1:0] o_sprx;
  logic signed [CORDW-1:0] o_spry;
  logic [ADDRW-1:0]        o_base_addr;
  logic                    o_spr_start;
  logic                    o_wrap;
  logic [1:0]              o_state;

  modport master (
    output i_frame, i_line, i_sy, i_run, i_key_n, i_dir,
    input  o_sprx, o_spry, o_base_addr, o_spr_start, o_wrap, o_state
  );

  modport slave (
    input  i_frame, i_line, i_sy, i_run, i_key_n, i_dir,
    output o_sprx, o_spry, o_base_addr, o_spr_start, o_wrap, o_state
  );
endinterface

// File: rtl/sprite_sequencer.sv
// Per-frame controller for a walking sprite: IDLE/WALK/PAUSE state machine,
// horizontal motion with wrap, and animation-frame ROM base selection.
// Optional macro SPRITE_SEQUENCER_BOB_EN: lowers the sprite by two lines
// while a non-zero graphic frame is shown (walking bob effect).
module sprite_sequencer #(
  parameter int CORDW       = 16,
  parameter int H_RES       = 800,
  parameter int X_MIN       = -132,
  parameter int Y_POS       = 240,
  parameter int SPEED       = 2,
  parameter int SPR_PIXELS  = 640,
  parameter int SPR_FRAMES  = 3,
  parameter int ANIM_PERIOD = 16,
  parameter int ADDRW       = $clog2(SPR_PIXELS*SPR_FRAMES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sprite_sequencer_if.slave    bus
);

  localparam int SEQ_LEN = 2*(SPR_FRAMES-1);
  localparam int STEPW   = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
  localparam int CNTW    = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  localparam logic signed [CORDW-1:0] HRES_S  = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] XMIN_S  = CORDW'(X_MIN);
  localparam logic signed [CORDW-1:0] YPOS_S  = CORDW'(Y_POS);
  localparam logic signed [CORDW-1:0] SPEED_S = CORDW'(SPEED);
  localparam logic [ADDRW-1:0]        PIX_A   = ADDRW'(SPR_PIXELS);
  localparam logic [STEPW-1:0]        STEP_LAST = STEPW'(SEQ_LEN-1);
  localparam logic [CNTW-1:0]         CNT_LAST  = CNTW'(ANIM_PERIOD-1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t                  state;
  logic signed [CORDW-1:0] sprx;
  logic signed [CORDW-1:0] spry;
  logic [ADDRW-1:0]        base;
  logic [ADDRW-1:0]        odd_base;
  logic [STEPW-1:0]        step;
  logic [CNTW-1:0]         cnt;
  logic                    wrap;
  logic                    pending;
  logic                    key_s1, key_s2, key_s3;
  logic                    press;
  logic                    pend_eff;

  // A press on the same cycle as the frame pulse still counts for that frame.
  assign press    = key_s3 & ~key_s2;
  assign pend_eff = pending | press;

  assign bus.o_sprx      = sprx;
  assign bus.o_spry      = spry;
  assign bus.o_base_addr = base;
  assign bus.o_wrap      = wrap;
  assign bus.o_state     = state;
  assign bus.o_spr_start = bus.i_line && (bus.i_sy == spry);

  // Key synchroniser, pause-pending flag, state machine, motion and animation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sprx     <= HRES_S;
      spry     <= YPOS_S;
      base     <= '0;
      odd_base <= PIX_A;
      step     <= '0;
      cnt      <= '0;
      wrap     <= 1'b0;
      pending  <= 1'b0;
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_s3   <= 1'b1;
    end else begin
      key_s1 <= bus.i_key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      wrap   <= 1'b0;
      if (press) pending <= 1'b1;

      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (bus.i_frame) begin
            base     <= '0;
            odd_base <= PIX_A;
            step     <= '0;
            cnt      <= '0;
            spry     <= YPOS_S;
            if (bus.i_run) state <= WALK;
          end
        end

        WALK, PAUSE: begin
          if (bus.i_frame) begin
            if (!bus.i_run) begin
              state    <= IDLE;
              sprx     <= bus.i_dir ? XMIN_S : HRES_S;
              base     <= '0;
              odd_base <= PIX_A;
              step     <= '0;
              cnt      <= '0;
              spry     <= YPOS_S;
            end else if (pend_eff) begin
              state   <= (state == WALK) ? PAUSE : WALK;
              pending <= 1'b0;
            end else if (state == WALK) begin
              if (!bus.i_dir) begin
                if (sprx > XMIN_S) sprx <= sprx - SPEED_S;
                else begin
                  sprx <= HRES_S;
                  wrap <= 1'b1;
                end
              end else begin
                if (sprx < HRES_S) sprx <= sprx + SPEED_S;
                else begin
                  sprx <= XMIN_S;
                  wrap <= 1'b1;
                end
              end

              if (cnt == CNT_LAST) begin
                cnt <= '0;
                // Even steps move to an odd step (non-zero frame); odd steps
                // return to frame 0, and the last step restarts the sequence.
                if (!step[0]) begin
                  step     <= step + 1'b1;
                  base     <= odd_base;
                  odd_base <= odd_base + PIX_A;
`ifdef SPRITE_SEQUENCER_BOB_EN
                  spry     <= YPOS_S - CORDW'(2);
`endif
                end else begin
                  base <= '0;
`ifdef SPRITE_SEQUENCER_BOB_EN
                  spry <= YPOS_S;
`endif
                  if (step == STEP_LAST) begin
                    step     <= '0;
                    odd_base <= PIX_A;
                  end else begin
                    step <= step + 1'b1;
                  end
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Directed self-checking bench for sprite_sequencer: reset, walking,
// animation, wrap in both directions, pause/resume, key bounce, return to
// idle and line-start strobe. Honours SPRITE_SEQUENCER_BOB_EN for o_spry.
module tb_sprite_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sprite_sequencer_if bus ();

  sprite_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Expected sprite top line for a given ROM base.
  function automatic int expSpry(input int base);
`ifdef SPRITE_SEQUENCER_BOB_EN
    return (base != 0) ? 238 : 240;
`else
    return 240;
`endif
  endfunction

  // Issue n frame pulses; returns on the falling edge right after the last one.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge clk);
      bus.i_frame = 1'b1;
      @(negedge clk);
      bus.i_frame = 1'b0;
    end
  endtask

  // Hold the pause key low for 5 cycles, then release and let it settle.
  task automatic pressKey();
    @(negedge clk);
    bus.i_key_n = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_key_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.i_frame = 1'b0;
    bus.i_line  = 1'b0;
    bus.i_sy    = '0;
    bus.i_run   = 1'b0;
    bus.i_key_n = 1'b1;
    bus.i_dir   = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_state", bus.o_state, 0);
    checkOutput("rst_sprx", bus.o_sprx, 800);
    checkOutput("rst_spry", bus.o_spry, 240);
    checkOutput("rst_base", bus.o_base_addr, 0);
    checkOutput("rst_wrap", bus.o_wrap, 0);
    rst_n = 1'b1;

    // Start walking right-to-left.
    bus.i_run = 1'b1;
    applyStimulus(1);
    checkOutput("walk_enter_state", bus.o_state, 1);
    checkOutput("walk_enter_x", bus.o_sprx, 800);
    applyStimulus(1);
    checkOutput("walk_first_move", bus.o_sprx, 798);
    repeat (5) @(negedge clk);
    checkOutput("hold_between_frames", bus.o_sprx, 798);

    applyStimulus(15);
    checkOutput("anim16_base", bus.o_base_addr, 640);
    checkOutput("anim16_spry", bus.o_spry, expSpry(640));
    checkOutput("anim16_x", bus.o_sprx, 768);
    applyStimulus(16);
    checkOutput("anim32_base", bus.o_base_addr, 0);
    checkOutput("anim32_spry", bus.o_spry, expSpry(0));
    applyStimulus(16);
    checkOutput("anim48_base", bus.o_base_addr, 1280);
    checkOutput("anim48_spry", bus.o_spry, expSpry(1280));
    applyStimulus(16);
    checkOutput("anim64_base", bus.o_base_addr, 0);
    checkOutput("anim64_x", bus.o_sprx, 672);

    // Five more moves leave the animation counter at 5, then pause.
    applyStimulus(5);
    checkOutput("pre_pause_x", bus.o_sprx, 662);
    pressKey();
    applyStimulus(1);
    checkOutput("pause_state", bus.o_state, 2);
    applyStimulus(10);
    checkOutput("pause_hold_state", bus.o_state, 2);
    checkOutput("pause_hold_x", bus.o_sprx, 662);
    checkOutput("pause_hold_base", bus.o_base_addr, 0);

    // Resume: no move on the resume frame, counter continues from 5.
    pressKey();
    applyStimulus(1);
    checkOutput("resume_state", bus.o_state, 1);
    checkOutput("resume_x", bus.o_sprx, 662);
    applyStimulus(10);
    checkOutput("resume10_base", bus.o_base_addr, 0);
    checkOutput("resume10_x", bus.o_sprx, 642);
    applyStimulus(1);
    checkOutput("resume11_base", bus.o_base_addr, 640);
    checkOutput("resume11_x", bus.o_sprx, 640);

    // Right-to-left wrap.
    applyStimulus(386);
    checkOutput("left_bound_x", bus.o_sprx, -132);
    checkOutput("left_bound_wrap", bus.o_wrap, 0);
    applyStimulus(1);
    checkOutput("wrap_l_x", bus.o_sprx, 800);
    checkOutput("wrap_l_pulse", bus.o_wrap, 1);
    @(negedge clk);
    checkOutput("wrap_l_clear", bus.o_wrap, 0);

    // Left-to-right: already at H_RES, so first frame wraps to X_MIN.
    bus.i_dir = 1'b1;
    applyStimulus(1);
    checkOutput("wrap_r0_x", bus.o_sprx, -132);
    checkOutput("wrap_r0_pulse", bus.o_wrap, 1);
    applyStimulus(466);
    checkOutput("right_bound_x", bus.o_sprx, 800);
    checkOutput("right_bound_wrap", bus.o_wrap, 0);
    applyStimulus(1);
    checkOutput("wrap_r_x", bus.o_sprx, -132);
    checkOutput("wrap_r_pulse", bus.o_wrap, 1);
    @(negedge clk);
    checkOutput("wrap_r_clear", bus.o_wrap, 0);

    // Pause, then drop run with dir=1.
    applyStimulus(3);
    checkOutput("pre_idle_x", bus.o_sprx, -126);
    pressKey();
    applyStimulus(1);
    checkOutput("pause2_state", bus.o_state, 2);
    bus.i_run = 1'b0;
    applyStimulus(1);
    checkOutput("idle_state", bus.o_state, 0);
    checkOutput("idle_x", bus.o_sprx, -132);
    checkOutput("idle_base", bus.o_base_addr, 0);
    checkOutput("idle_spry", bus.o_spry, 240);

    // Bouncing key: two presses before one frame give a single toggle.
    bus.i_run = 1'b1;
    applyStimulus(1);
    checkOutput("rewalk_state", bus.o_state, 1);
    pressKey();
    pressKey();
    applyStimulus(1);
    checkOutput("bounce_state", bus.o_state, 2);
    applyStimulus(1);
    checkOutput("bounce_stays", bus.o_state, 2);

    // Line-start strobe is combinational.
    @(negedge clk);
    bus.i_line = 1'b1;
    bus.i_sy   = 16'sd240;
    #1;
    checkOutput("start_match", bus.o_spr_start, 1);
    bus.i_sy = 16'sd239;
    #1;
    checkOutput("start_other_line", bus.o_spr_start, 0);
    bus.i_sy   = 16'sd240;
    bus.i_line = 1'b0;
    #1;
    checkOutput("start_no_line", bus.o_spr_start, 0);

    // Resume walking, then reset asynchronously mid-walk.
    pressKey();
    applyStimulus(1);
    checkOutput("prereset_state", bus.o_state, 1);
    applyStimulus(2);
    checkOutput("prereset_x", bus.o_sprx, -128);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", bus.o_state, 0);
    checkOutput("async_rst_x", bus.o_sprx, 800);
    checkOutput("async_rst_y", bus.o_spry, 240);
    checkOutput("async_rst_base", bus.o_base_addr, 0);
    checkOutput("async_rst_wrap", bus.o_wrap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_sequencer.md
Name: sprite_sequencer

Overview:
- Per-frame controller for one walking sprite engine plus its graphic ROM.
- Owns the sprite state machine (IDLE/WALK/PAUSE), horizontal motion with wrap, and animation-frame selection.
- Produces the ROM base address, sprite position and line-start pulse consumed by the sprite engine.
- Sits between display timing (frame/line/sy) and the sprite datapath; user inputs come from KEY0 and SW0.

Parameters:
- CORDW, 16, signed screen-coordinate width.
- H_RES, 800, right-hand start/wrap position.
- X_MIN, -132, left wrap bound (signed); covers scaled sprite width.
- Y_POS, 240, sprite top line.
- SPEED, 2, pixels moved per video frame.
- SPR_PIXELS, 640, pixels per graphic frame.
- SPR_FRAMES, 3, graphic frames in ROM (>=2).
- ANIM_PERIOD, 16, video frames per animation step.
- ADDRW, $clog2(SPR_PIXELS*SPR_FRAMES), ROM address width.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame  in  1  one-cycle pulse at start of blanking each frame
- i_line  in  1  one-cycle pulse per line
- i_sy  in  CORDW signed  current line
- i_run  in  1  level; 1 = sprite active
- i_key_n  in  1  raw active-low pause button, asynchronous
- i_dir  in  1  0 = right-to-left, 1 = left-to-right
- o_sprx  out  CORDW signed  sprite left x
- o_spry  out  CORDW signed  sprite top y
- o_base_addr  out  ADDRW  ROM base of current graphic frame
- o_spr_start  out  1  sprite line-start strobe
- o_wrap  out  1  one-cycle pulse when x wraps
- o_state  out  2  00 IDLE, 01 WALK, 10 PAUSE

Behaviour:
- Reset (async, i_rst_n=0) values:
  - state IDLE; o_sprx=H_RES; o_spry=Y_POS; o_base_addr=0; o_wrap=0.
  - Step index 0, anim counter 0, pause-pending 0, key sync flops 1.
- Key input:
  - 2-flop synchroniser, then falling-edge detect produces a one-cycle press.
  - A press sets pause-pending.
  - A press coincident with i_frame is applied at that i_frame.
- All state, position and address updates occur only on cycles with i_frame=1. Otherwise everything holds; o_wrap is cleared every cycle it is not set.
- IDLE:
  - o_base_addr=0, step=0, counter=0; position held; pending cleared.
  - On i_frame with i_run=1: go to WALK. No move in that frame.
- WALK, on i_frame, in this priority:
  1. i_run=0: go to IDLE; o_sprx = H_RES if i_dir=0, X_MIN if i_dir=1; base/step/counter = 0.
  2. Pending: go to PAUSE, clear pending, no move.
  3. Otherwise move and animate (below).
- Motion (WALK only):
  - i_dir=0: if o_sprx > X_MIN, o_sprx -= SPEED; else o_sprx = H_RES and o_wrap=1.
  - i_dir=1: if o_sprx < H_RES, o_sprx += SPEED; else o_sprx = X_MIN and o_wrap=1.
  - Signed compare. i_dir changing mid-walk only changes direction; no reposition.
- Animation (WALK only):
  - Counter 0..ANIM_PERIOD-1. On terminal count, counter=0 and step advances.
  - Step range 0..SEQ_LEN-1 where SEQ_LEN = 2*(SPR_FRAMES-1); wraps to 0.
  - Step k maps to graphic frame: 0 if k even; 1+(k-1)/2 if k odd. Default sequence: 0,1,0,2.
  - o_base_addr = frame*SPR_PIXELS, registered on the same edge the step changes. Use accumulate or constant table, no multiplier.
- PAUSE:
  - Position, step, counter and base frozen.
  - On i_frame: i_run=0 goes to IDLE (same actions as WALK rule 1); else pending goes to WALK and clears pending.
- o_spr_start is combinational: i_line && (i_sy == o_spry), in all states.
- o_state encodes 11 never; an illegal state recovers to IDLE on the next clock.

Optional Feature:
- Macro: SPRITE_SEQUENCER_BOB_EN.
- Defined: in WALK, o_spry = Y_POS-2 while the current graphic frame is non-zero, else Y_POS. Updated with o_base_addr; PAUSE holds it; IDLE restores Y_POS.
- Undefined: o_spry constant Y_POS.

Test Plan:
- Reset mid-walk (o_sprx=500) -> same-cycle o_state=00, o_sprx=800, o_spry=240, o_base_addr=0, o_wrap=0.
- i_run=1, i_dir=0, frame pulses -> frame 1: WALK, x=800; frame 2: x=798. After 16/32/48/64 moving frames, base = 640/0/1280/0.
- Wrap with i_dir=0: x reaches -132 after 466 moves; next frame x=800 and o_wrap high exactly one cycle. i_dir=1 from -132 reaches 800, then wraps to -132.
- Pause: i_key_n low for 5 cycles mid-frame -> next frame state 10; x and base frozen over 10 frames. Second press -> WALK; motion resumes from the frozen x, step continues from its count.
- i_run=0 while PAUSE, i_dir=1 -> next frame IDLE, x=-132, base=0. Bouncing key (two presses between frames) -> single toggle.
- i_line with i_sy=240 -> o_spr_start=1 same cycle; i_sy=239 or i_line=0 -> 0. With SPRITE_SEQUENCER_BOB_EN: o_spry=238 while base=640/1280, 240 while base=0.
